// File: rtl/csa_resolver_pkg.sv
// Shared types and elaboration helpers for the multi-cycle carry-save resolver.
// Optional build macro: CSA_RESOLVER_EARLY_DONE_EN (see csa_resolver.sv).
package csa_resolver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned rw(input int unsigned width);
    return width + 2;
  endfunction

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : (rw(width) + chunk - 1) / chunk;
  endfunction

  // Counter width for the chunk index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned chunk,
                                input int unsigned approx_lsb);
    if (width < 1 || chunk < 1) return 1'b0;
    if (chunk > rw(width)) return 1'b0;
    if (approx_lsb > rw(width)) return 1'b0;
    return (approx_lsb % chunk) == 0;
  endfunction

endpackage

// File: rtl/csa_resolver_chunk_adder.sv
// CHUNK-bit adder slice with an approximate mode (bitwise OR, carry killed).
module csa_chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic             approx,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    if (approx) begin
      s    = a | b;
      cout = 1'b0;
    end else begin
      s    = full[CHUNK-1:0];
      cout = full[CHUNK];
    end
  end

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair into sum + 2*carry, CHUNK bits per cycle.
// Build macro CSA_RESOLVER_EARLY_DONE_EN: finish as soon as the remaining chunks are all zero.
module csa_resolver
  import csa_resolver_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHUNK      = 4,
  parameter int unsigned APPROX_LSB = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   sum_in,
  input  logic [WIDTH-1:0]   carry_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   result,
  output logic               busy
);

  localparam int unsigned RW      = rw(WIDTH);
  localparam int unsigned NCHUNK  = nchunk(WIDTH, CHUNK);
  localparam int unsigned NAPPROX = APPROX_LSB / CHUNK;
  localparam int unsigned KW      = idx_width(NCHUNK);
  localparam bit          CFG_OK  = cfg_ok(WIDTH, CHUNK, APPROX_LSB);

  if (!CFG_OK) begin : g_bad_cfg
    $error("csa_resolver: illegal WIDTH/CHUNK/APPROX_LSB combination");
  end

  state_t            state_q;
  logic [RW-1:0]     a_q;
  logic [RW-1:0]     b_q;
  logic [RW-1:0]     result_q;
  logic [KW-1:0]     k_q;
  logic              c_q;
  logic              busy_q;
  logic              out_valid_q;

  logic [CHUNK-1:0]  a_cur;
  logic [CHUNK-1:0]  b_cur;
  logic [CHUNK-1:0]  r;
  logic              cout;
  logic              approx;
  logic              last;
  logic              done_now;
  logic [RW-1:0]     result_d;

  // Chunk i of an RW-bit vector; bits past RW read as zero.
  function automatic logic [CHUNK-1:0] chunk_of(input logic [RW-1:0] v, input int unsigned i);
    logic [CHUNK-1:0] c;
    c = '0;
    for (int unsigned j = 0; j < CHUNK; j++) begin
      if (i * CHUNK + j < RW) c[j] = v[i*CHUNK+j];
    end
    return c;
  endfunction

  always_comb begin
    a_cur  = '0;
    b_cur  = '0;
    approx = 1'b0;
    last   = 1'b0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        a_cur  = chunk_of(a_q, i);
        b_cur  = chunk_of(b_q, i);
        approx = (i < NAPPROX);
        last   = (i == NCHUNK - 1);
      end
    end
  end

  csa_chunk_adder #(.CHUNK(CHUNK)) u_adder (
    .a      (a_cur),
    .b      (b_cur),
    .cin    (c_q),
    .approx (approx),
    .s      (r),
    .cout   (cout)
  );

  always_comb begin
    result_d = result_q;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      for (int unsigned j = 0; j < CHUNK; j++) begin
        if (k_q == KW'(i) && (i * CHUNK + j < RW)) result_d[i*CHUNK+j] = r[j];
      end
    end
  end

`ifdef CSA_RESOLVER_EARLY_DONE_EN
  logic hi_zero;

  // Nothing left to add once every higher chunk is zero and no carry escapes.
  always_comb begin
    hi_zero = 1'b1;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if ((KW'(i) > k_q) && ((chunk_of(a_q, i) | chunk_of(b_q, i)) != '0)) hi_zero = 1'b0;
    end
    done_now = last || (hi_zero && !cout);
  end
`else
  always_comb begin
    done_now = last;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      k_q         <= '0;
      c_q         <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= {2'b00, sum_in};
            b_q      <= {1'b0, carry_in, 1'b0};
            result_q <= '0;
            k_q      <= '0;
            c_q      <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          result_q <= result_d;
          c_q      <= cout;
          k_q      <= k_q + KW'(1);
          if (done_now) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Directed self-checking bench for csa_resolver (exact and APPROX_LSB=4 instances).
module tb_csa_resolver;

`ifdef CSA_RESOLVER_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] sum_in = '0;
  logic [7:0] carry_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] result;
  logic       busy;

  logic       ax_in_valid = 1'b0;
  logic       ax_in_ready;
  logic [7:0] ax_sum_in = '0;
  logic [7:0] ax_carry_in = '0;
  logic       ax_out_valid;
  logic       ax_out_ready = 1'b0;
  logic [9:0] ax_result;
  logic       ax_busy;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csa_resolver #(.WIDTH(8), .CHUNK(4), .APPROX_LSB(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  csa_resolver #(.WIDTH(8), .CHUNK(4), .APPROX_LSB(4)) dut_ax (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (ax_in_valid),
    .in_ready  (ax_in_ready),
    .sum_in    (ax_sum_in),
    .carry_in  (ax_carry_in),
    .out_valid (ax_out_valid),
    .out_ready (ax_out_ready),
    .result    (ax_result),
    .busy      (ax_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic [7:0] s, input logic [7:0] c,
                         input logic [9:0] exp, input int exp_lat, input bit complete);
    int lat;
    int nbusy;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    sum_in   = s;
    carry_in = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    nbusy = busy ? 1 : 0;
    lat   = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) nbusy++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(nbusy), 32'(exp_lat));
    check({tag, "_res"}, 32'(result), 32'(exp));
    if (complete) begin
      @(posedge clk); #1;
      check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int lat;
    #12;
    check("rst_res", 32'(result), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn("ff", 8'hFF, 8'hFF, 10'h2FD, 3, 1'b1);
    run_txn("zero", 8'h00, 8'h00, 10'h000, EARLY ? 1 : 3, 1'b1);

    // Back-to-back issue with out_ready held high
    run_txn("b2b1", 8'h12, 8'h34, 10'h07A, EARLY ? 2 : 3, 1'b1);
    acc1 = acc_cyc;
    run_txn("b2b2", 8'h80, 8'h80, 10'h180, 3, 1'b1);
    check("b2b_gap", 32'(acc_cyc - acc1), EARLY ? 32'd4 : 32'd5);

    // Backpressure: result must hold and new operands must be ignored
    out_ready = 1'b0;
    run_txn("bp", 8'h33, 8'h11, 10'h055, EARLY ? 2 : 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sum_in   = 8'hA0 + 8'(i);
      carry_in = 8'h5F;
      in_valid = ~in_valid;
      @(posedge clk); #1;
      check("bp_res", 32'(result), 32'h055);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_vdrop", 32'(out_valid), 32'd0);
    check("bp_rdy", 32'(in_ready), 32'd1);
    check("bp_hold", 32'(result), 32'h055);

    // Asynchronous reset while the second chunk is pending
    sum_in   = 8'hFF;
    carry_in = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_res", 32'(result), 32'd0);
    check("mid_ready", 32'(in_ready), 32'd1);
    check("mid_busy0", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn("post", 8'h01, 8'h01, 10'h003, EARLY ? 1 : 3, 1'b1);

    // Approximate low chunk: OR instead of add in bits [3:0]
    ax_sum_in   = 8'h0F;
    ax_carry_in = 8'h01;
    ax_in_valid = 1'b1;
    @(posedge clk); #1;
    ax_in_valid = 1'b0;
    lat = 0;
    while (!ax_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ax_valid", 32'(ax_out_valid), 32'd1);
    check("ax_lat", 32'(lat), EARLY ? 32'd1 : 32'd3);
    check("ax_res", 32'(ax_result), 32'h00F);
    ax_out_ready = 1'b1;
    @(posedge clk); #1;
    check("ax_rdy", 32'(ax_in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
